aes_round_ctrl: RTL and testbench

Round sequencer that sits directly upstream of the AES round block. It accepts one 128-bit plaintext and 128-bit key per transaction and performs the initial AddRoundKey (whitening) itself. It then drives the round block through rounds 1..10, handshaking on its trigger/busy pair, feeding each round's output back as the next round's input. The final round output is presented as ciphertext with a one-cycle valid pulse.

---
 rtl/aes_round_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_aes_round_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: whitening, ten trigger/busy handshakes with a round block, ciphertext out.
// aes_round_blk is a multi-cycle AES round engine that speaks the blk_* handshake.

module aes_round_ctrl #(
    parameter int WIDTH   = 128,
    parameter int ROUNDS  = 10,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] key_in,
    output logic             ready,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             error,
    output logic             blk_sample_trig,
    output logic             blk_first_round,
    output logic             blk_end_round,
    output logic [3:0]       blk_count,
    output logic [WIDTH-1:0] blk_data,
    output logic [WIDTH-1:0] blk_key,
    input  logic [WIDTH-1:0] blk_data_out,
    input  logic             blk_busy
);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE,
        DONE
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [7:0]       tmo_q, tmo_d;
    logic             ready_q, ready_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             error_q, error_d;
    logic             trig_q, trig_d;
    logic             first_q, first_d;
    logic             end_q, end_d;
    logic [3:0]       count_q, count_d;
    logic [WIDTH-1:0] blk_data_q, blk_data_d;
    logic [WIDTH-1:0] blk_key_q, blk_key_d;
    logic             abort;

    always_comb begin
        state_d      = state_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        error_d      = error_q;
        first_d      = first_q;
        end_d        = end_q;
        count_d      = count_q;
        blk_data_d   = blk_data_q;
        blk_key_d    = blk_key_q;
        abort        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    blk_data_d = data_in ^ key_in;
                    blk_key_d  = key_in;
                    count_d    = 4'd1;
                    first_d    = 1'b1;
                    end_d      = 1'b0;
                    state_d    = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (blk_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    abort = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!blk_busy) begin
                    if (count_q < LAST_ROUND) begin
                        blk_data_d = blk_data_out;
                        count_d    = count_q + 4'd1;
                        first_d    = 1'b0;
                        end_d      = ((count_q + 4'd1) == LAST_ROUND);
                        state_d    = LAUNCH;
                    end else begin
                        data_out_d   = blk_data_out;
                        data_valid_d = 1'b1;
                        state_d      = DONE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    abort = 1'b1;
                end
            end
            DONE: begin
                first_d = 1'b0;
                end_d   = 1'b0;
                count_d = 4'd0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A stalled handshake abandons the transaction without touching data_out.
        if (abort) begin
            error_d = 1'b1;
            first_d = 1'b0;
            end_d   = 1'b0;
            count_d = 4'd0;
            state_d = IDLE;
        end

        if (state_d != state_q) begin
            tmo_d = 8'd0;
        end else if (state_q == WAIT_BUSY || state_q == WAIT_DONE) begin
            tmo_d = tmo_q + 8'd1;
        end else begin
            tmo_d = tmo_q;
        end

        ready_d = (state_d == IDLE);
        trig_d  = (state_d == LAUNCH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            tmo_q        <= 8'd0;
            ready_q      <= 1'b1;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            error_q      <= 1'b0;
            trig_q       <= 1'b0;
            first_q      <= 1'b0;
            end_q        <= 1'b0;
            count_q      <= 4'd0;
            blk_data_q   <= '0;
            blk_key_q    <= '0;
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            ready_q      <= ready_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            error_q      <= error_d;
            trig_q       <= trig_d;
            first_q      <= first_d;
            end_q        <= end_d;
            count_q      <= count_d;
            blk_data_q   <= blk_data_d;
            blk_key_q    <= blk_key_d;
        end
    end

    assign ready           = ready_q;
    assign data_out        = data_out_q;
    assign data_valid      = data_valid_q;
    assign error           = error_q;
    assign blk_sample_trig = trig_q;
    assign blk_first_round = first_q;
    assign blk_end_round   = end_q;
    assign blk_count       = count_q;
    assign blk_data        = blk_data_q;
    assign blk_key         = blk_key_q;

endmodule

module aes_round_blk #(
    parameter int LATENCY = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sample_trig,
    input  logic         first_round,
    input  logic         end_round,
    input  logic [3:0]   count,
    input  logic [127:0] data,
    input  logic [127:0] key,
    output logic [127:0] data_out,
    output logic         busy
);

    localparam logic [7:0] INV_EXP = 8'd254;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (b^254, with 0 -> 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            inv = gf_mul(inv, inv);
            if (INV_EXP[i]) inv = gf_mul(inv, b);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] rot, t, n0, n1, n2, n3;
        rot = {k[23:0], k[31:24]};
        t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rc, 24'h0};
        n0  = k[127:96] ^ t;
        n1  = k[95:64] ^ n0;
        n2  = k[63:32] ^ n1;
        n3  = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Byte 0 is the most significant byte; bytes run down columns (index 4*col + row).
    function automatic logic [127:0] round_fn(input logic [127:0] st, input logic [127:0] rk,
                                              input logic last);
        logic [127:0] sb, sr, mc;
        logic [7:0]   a0, a1, a2, a3;
        for (int i = 0; i < 16; i++) begin
            sb[127-8*i -: 8] = sbox(st[127-8*i -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            a0 = sr[127-32*c -: 8];
            a1 = sr[119-32*c -: 8];
            a2 = sr[111-32*c -: 8];
            a3 = sr[103-32*c -: 8];
            mc[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mc[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mc[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mc[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return (last ? sr : mc) ^ rk;
    endfunction

    logic [127:0] rk_q, rk_d;
    logic [127:0] out_q, out_d;
    logic         busy_q, busy_d;
    logic [7:0]   cnt_q, cnt_d;

    always_comb begin
        rk_d   = rk_q;
        out_d  = out_q;
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (sample_trig) begin
            rk_d   = key_expand(first_round ? key : rk_q, rcon(count));
            out_d  = round_fn(data, rk_d, end_round);
            busy_d = 1'b1;
            cnt_d  = 8'(LATENCY - 1);
        end else if (busy_q) begin
            if (cnt_q == 8'd0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rk_q   <= '0;
            out_q  <= '0;
            busy_q <= 1'b0;
            cnt_q  <= 8'd0;
        end else begin
            rk_q   <= rk_d;
            out_q  <= out_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign data_out = out_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with the multi-cycle round block attached (busy lasts 5 cycles).
// A bench-side switch can hold blk_busy low to force the handshake timeout.

module tb_aes_round_ctrl;

    localparam int LAT = 5;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [127:0] data_in = '0;
    logic [127:0] key_in = '0;
    logic         ready;
    logic [127:0] data_out;
    logic         data_valid;
    logic         error;
    logic         blk_sample_trig;
    logic         blk_first_round;
    logic         blk_end_round;
    logic [3:0]   blk_count;
    logic [127:0] blk_data;
    logic [127:0] blk_key;
    logic [127:0] blk_data_out;
    logic         blk_busy;
    logic         rb_busy;
    logic         no_busy = 1'b0;

    int total = 0;
    int bad = 0;

    assign blk_busy = no_busy ? 1'b0 : rb_busy;

    always #5 clk = ~clk;

    aes_round_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .data_in         (data_in),
        .key_in          (key_in),
        .ready           (ready),
        .data_out        (data_out),
        .data_valid      (data_valid),
        .error           (error),
        .blk_sample_trig (blk_sample_trig),
        .blk_first_round (blk_first_round),
        .blk_end_round   (blk_end_round),
        .blk_count       (blk_count),
        .blk_data        (blk_data),
        .blk_key         (blk_key),
        .blk_data_out    (blk_data_out),
        .blk_busy        (blk_busy)
    );

    aes_round_blk #(.LATENCY(LAT)) rb (
        .clk         (clk),
        .reset       (reset),
        .sample_trig (blk_sample_trig),
        .first_round (blk_first_round),
        .end_round   (blk_end_round),
        .count       (blk_count),
        .data        (blk_data),
        .key         (blk_key),
        .data_out    (blk_data_out),
        .busy        (rb_busy)
    );

    // Running tallies of pulses and flag-rule violations, sampled on each rising edge.
    int         trig_total = 0;
    int         valid_total = 0;
    int         first_cyc = 0;
    int         end_cyc = 0;
    int         flag_err = 0;
    int         idle_err = 0;
    logic [3:0] trig_cnt_log [256];

    always @(posedge clk) begin
        if (blk_sample_trig) begin
            trig_cnt_log[trig_total[7:0]] <= blk_count;
            trig_total <= trig_total + 1;
        end
        if (data_valid) valid_total <= valid_total + 1;
        if (blk_first_round) first_cyc <= first_cyc + 1;
        if (blk_end_round) end_cyc <= end_cyc + 1;
        if ((blk_first_round && blk_count != 4'd1) || (blk_end_round && blk_count != 4'd10))
            flag_err <= flag_err + 1;
        if (ready && (blk_first_round || blk_end_round || blk_count != 4'd0))
            idle_err <= idle_err + 1;
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge with ready high; returns at the falling edge of the LAUNCH cycle.
    task automatic applyStimulus(input logic [127:0] pt, input logic [127:0] key);
        start   = 1'b1;
        data_in = pt;
        key_in  = key;
        @(negedge clk);
        start   = 1'b0;
        data_in = ~pt;
        key_in  = ~key;
    endtask

    task automatic waitValid(input bit noise, output logic [127:0] got, output logic seen);
        seen = 1'b0;
        got  = '0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            if (data_valid) begin
                seen = 1'b1;
                got  = data_out;
            end else begin
                start = noise && (i == 15 || i == 40);
                if (start) begin
                    data_in = {$urandom, $urandom, $urandom, $urandom};
                    key_in  = {$urandom, $urandom, $urandom, $urandom};
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0] got;
        logic         seen;
        int           base;
        int           vbase;

        // Reset held with start asserted: reset must win.
        reset   = 1'b1;
        start   = 1'b1;
        data_in = PT_C1;
        key_in  = KEY_C1;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", ready, 1);
        checkOutput("rst_data_out", data_out, 0);
        checkOutput("rst_valid", data_valid, 0);
        checkOutput("rst_error", error, 0);
        checkOutput("rst_trig", blk_sample_trig, 0);
        checkOutput("rst_first", blk_first_round, 0);
        checkOutput("rst_end", blk_end_round, 0);
        checkOutput("rst_count", blk_count, 0);
        checkOutput("rst_blk_data", blk_data, 0);
        checkOutput("rst_blk_key", blk_key, 0);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_wins_no_trig", trig_total, 0);
        checkOutput("rst_wins_ready", ready, 1);

        // FIPS-197 C.1
        base = trig_total;
        applyStimulus(PT_C1, KEY_C1);
        checkOutput("trig_after_accept", blk_sample_trig, 1);
        checkOutput("ready_low_in_launch", ready, 0);
        checkOutput("whitened_data", blk_data, PT_C1 ^ KEY_C1);
        checkOutput("key_captured", blk_key, KEY_C1);
        checkOutput("launch_count", blk_count, 1);
        waitValid(1'b0, got, seen);
        checkOutput("c1_valid_seen", seen, 1);
        checkOutput("c1_ciphertext", got, CT_C1);
        @(negedge clk);
        checkOutput("valid_one_cycle", data_valid, 0);
        checkOutput("ready_after_valid", ready, 1);
        checkOutput("data_out_holds", data_out, CT_C1);
        checkOutput("c1_trig_pulses", trig_total - base, 10);
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("round_seq_%0d", i + 1), trig_cnt_log[(base + i) % 256], i + 1);
        end
        checkOutput("first_round_cycles", first_cyc, LAT + 2);
        checkOutput("end_round_span_ok", (end_cyc >= LAT + 2) && (end_cyc <= LAT + 3), 1);
        checkOutput("flag_rule_errors", flag_err, 0);
        checkOutput("idle_flag_errors", idle_err, 0);
        checkOutput("c1_valid_pulses", valid_total, 1);

        // Back-to-back with stray start pulses while busy
        base  = trig_total;
        vbase = valid_total;
        applyStimulus(PT_C1, KEY_C1);
        waitValid(1'b1, got, seen);
        checkOutput("b2b_first_seen", seen, 1);
        checkOutput("b2b_first_ct", got, CT_C1);
        @(negedge clk);
        checkOutput("b2b_ready_back", ready, 1);
        applyStimulus(PT_B, KEY_B);
        checkOutput("b2b_second_trig", blk_sample_trig, 1);
        waitValid(1'b1, got, seen);
        checkOutput("b2b_second_seen", seen, 1);
        checkOutput("b2b_second_ct", got, CT_B);
        @(negedge clk);
        checkOutput("b2b_trig_pulses", trig_total - base, 20);
        checkOutput("b2b_valid_pulses", valid_total - vbase, 2);
        checkOutput("b2b_idle_flag_errors", idle_err, 0);

        // Timeout: round block busy never seen
        no_busy = 1'b1;
        vbase   = valid_total;
        applyStimulus(PT_C1, KEY_C1);
        repeat (255) @(negedge clk);
        checkOutput("tmo_error_not_early", error, 0);
        @(negedge clk);
        checkOutput("tmo_error_on_time", error, 1);
        @(negedge clk);
        checkOutput("tmo_ready", ready, 1);
        checkOutput("tmo_trig_clear", blk_sample_trig, 0);
        checkOutput("tmo_count_clear", blk_count, 0);
        checkOutput("tmo_first_clear", blk_first_round, 0);
        checkOutput("tmo_no_valid", valid_total - vbase, 0);
        checkOutput("tmo_data_out_kept", data_out, CT_B);
        no_busy = 1'b0;
        applyStimulus(PT_C1, KEY_C1);
        waitValid(1'b0, got, seen);
        checkOutput("post_tmo_seen", seen, 1);
        checkOutput("post_tmo_ct", got, CT_C1);
        checkOutput("error_sticky", error, 1);
        @(negedge clk);

        // Reset during round 5
        vbase = valid_total;
        applyStimulus(PT_C1, KEY_C1);
        seen = 1'b0;
        for (int i = 0; i < 500 && !seen; i++) begin
            if (blk_count == 4'd5) seen = 1'b1;
            else @(negedge clk);
        end
        checkOutput("reached_round5", seen, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midrst_ready", ready, 1);
        checkOutput("midrst_count", blk_count, 0);
        checkOutput("midrst_first", blk_first_round, 0);
        checkOutput("midrst_end", blk_end_round, 0);
        checkOutput("midrst_trig", blk_sample_trig, 0);
        checkOutput("midrst_blk_data", blk_data, 0);
        checkOutput("midrst_blk_key", blk_key, 0);
        checkOutput("midrst_error", error, 0);
        checkOutput("midrst_data_out", data_out, 0);
        checkOutput("midrst_valid", data_valid, 0);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("midrst_no_valid", valid_total - vbase, 0);
        applyStimulus(PT_C1, KEY_C1);
        waitValid(1'b0, got, seen);
        checkOutput("restart_seen", seen, 1);
        checkOutput("restart_ct", got, CT_C1);
        @(negedge clk);
        checkOutput("final_flag_errors", flag_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
